// File: rtl/spi_codec_reg_slave_pkg.sv
// Shared constants and types for the codec control-register SPI responder.
// Frame layout: 7-bit address, read flag, 8-bit data, MSB first.
package spi_codec_reg_slave_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int RW_BIT     = 8;
  localparam int BC_W       = $clog2(FRAME_BITS + 1);
  localparam int NREGS      = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [BC_W-1:0]   bc_t;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    addr_t addr;
    logic  rd;
    data_t data;
  } frame_t;

endpackage

// File: rtl/spi_codec_reg_slave_if.sv
// SPI pad bundle between the configuration master and the register slave.
// Signal names follow the board-level pin names.
interface spi_codec_reg_slave_if;

  logic iSCLK;
  logic iCS_n;
  logic iDIN;
  logic oDOUT;
  logic oDOUT_EN;

  modport master (
    output iSCLK,
    output iCS_n,
    output iDIN,
    input  oDOUT,
    input  oDOUT_EN
  );

  modport slave (
    input  iSCLK,
    input  iCS_n,
    input  iDIN,
    output oDOUT,
    output oDOUT_EN
  );

endinterface

// File: rtl/spi_codec_regs.sv
// 128 x 8 register file: one synchronous write port, two async read ports.
// ID override is applied by the parent, not here.
module spi_codec_regs
  import spi_codec_reg_slave_pkg::*;
(
  input  logic  CLK_50,
  input  logic  RESET_n,
  input  logic  we,
  input  addr_t wa,
  input  data_t wd,
  input  addr_t ra,
  output data_t rd,
  input  addr_t ma,
  output data_t md
);

  data_t mem_q [NREGS];

  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd = mem_q[ra];
  assign md = mem_q[ma];

endmodule

// File: rtl/spi_codec_reg_slave.sv
// SPI responder emulating the codec's control-register file.
// Pins are synchronized to CLK_50; all SPI activity is edge-detected there.
module spi_codec_reg_slave
  import spi_codec_reg_slave_pkg::*;
#(
  parameter addr_t ID_ADDR  = 7'h00,
  parameter data_t ID_VAL   = 8'h01,
  parameter int    MIN_HALF = 8
) (
  input  logic        CLK_50,
  input  logic        RESET_n,
  spi_codec_reg_slave_if.slave spi,
  output logic        oWR_STB,
  output addr_t       oWR_ADDR,
  output data_t       oWR_DATA,
  output logic        oRD_STB,
  input  addr_t       iMON_ADDR,
  output data_t       oMON_DATA,
  output logic        oFRAME_ERR,
  output logic [15:0] oFRAME_CNT
);

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] din_q;

  // CS sync resets low so WAIT_IDLE only leaves once the pin is truly high.
  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      sclk_q <= 3'b111;
      cs_q   <= 3'b000;
      din_q  <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.iSCLK};
      cs_q   <= {cs_q[1:0], spi.iCS_n};
      din_q  <= {din_q[0], spi.iDIN};
    end
  end

  logic sclk_fall, sclk_rise, cs_fall, cs_rise;

  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign cs_fall   = cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] & cs_q[1];

  state_t      state_q, state_d;
  bc_t         bc_q, bc_d;
  logic [14:0] sr_q, sr_d;
  data_t       or_q, or_d;
  logic        rdf_q, rdf_d;
  logic        dout_q, dout_d;
  logic        wr_stb_q, wr_stb_d;
  logic        rd_stb_q, rd_stb_d;
  logic        err_q, err_d;
  addr_t       wr_addr_q, wr_addr_d;
  data_t       wr_data_q, wr_data_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hp_q, hp_d;

  logic [15:0] sr_nx;
  frame_t      fr;
  addr_t       rd_addr;
  data_t       rd_raw, rd_val, mon_raw;

  assign sr_nx   = {sr_q, din_q[1]};
  assign fr      = frame_t'(sr_nx);
  assign rd_addr = sr_nx[RW_BIT-1:1];
  assign rd_val  = (rd_addr == ID_ADDR) ? ID_VAL : rd_raw;

  spi_codec_regs u_regs (
    .CLK_50  (CLK_50),
    .RESET_n (RESET_n),
    .we      (wr_stb_q),
    .wa      (wr_addr_q),
    .wd      (wr_data_q),
    .ra      (rd_addr),
    .rd      (rd_raw),
    .ma      (iMON_ADDR),
    .md      (mon_raw)
  );

  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    sr_d      = sr_q;
    or_d      = or_q;
    rdf_d     = rdf_q;
    dout_d    = dout_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      WAIT_IDLE: begin
        if (cs_q[1]) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          bc_d    = '0;
          sr_d    = '0;
          or_d    = '0;
          rdf_d   = 1'b0;
          dout_d  = 1'b0;
        end
      end
      SHIFT: begin
        // CS release wins over an SCLK edge seen in the same cycle.
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
          dout_d  = 1'b0;
        end else if (sclk_fall) begin
          sr_d = sr_nx[14:0];
          bc_d = bc_q + 1'b1;
          if (bc_d == BC_W'(RW_BIT) && sr_nx[0]) begin
            rdf_d    = 1'b1;
            rd_stb_d = 1'b1;
            or_d     = rd_val;
          end
          if (bc_d == BC_W'(FRAME_BITS)) begin
            state_d = DONE;
            dout_d  = 1'b0;
            cnt_d   = cnt_q + 1'b1;
            if (!fr.rd && fr.addr != ID_ADDR) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = fr.addr;
              wr_data_d = fr.data;
            end
          end
        end else if (sclk_rise && rdf_q) begin
          dout_d = or_q[DATA_W-1];
          or_d   = {or_q[DATA_W-2:0], 1'b0};
        end
      end
      DONE: begin
        dout_d = 1'b0;
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    hp_d = hp_q;
    if (sclk_fall || sclk_rise) hp_d = '0;
    else if (hp_q != 8'hFF)     hp_d = hp_q + 1'b1;
  end

  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= WAIT_IDLE;
      bc_q      <= '0;
      sr_q      <= '0;
      or_q      <= '0;
      rdf_q     <= 1'b0;
      dout_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      hp_q      <= 8'hFF;
    end else begin
      state_q   <= state_d;
      bc_q      <= bc_d;
      sr_q      <= sr_d;
      or_q      <= or_d;
      rdf_q     <= rdf_d;
      dout_q    <= dout_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
    end
  end

  // SCLK half-periods shorter than MIN_HALF break the pin-to-action budget.
  always_ff @(posedge CLK_50) begin
    if (RESET_n && state_q == SHIFT && (sclk_fall || sclk_rise)) begin
      assert (int'(hp_q) >= MIN_HALF - 1);
    end
  end

  assign spi.oDOUT    = dout_q;
  assign spi.oDOUT_EN = ~cs_q[1] & (state_q != WAIT_IDLE);
  assign oWR_STB      = wr_stb_q;
  assign oWR_ADDR     = wr_addr_q;
  assign oWR_DATA     = wr_data_q;
  assign oRD_STB      = rd_stb_q;
  assign oFRAME_ERR   = err_q;
  assign oFRAME_CNT   = cnt_q;
  assign oMON_DATA    = (iMON_ADDR == ID_ADDR) ? ID_VAL : mon_raw;

endmodule

// File: tb/tb_spi_codec_reg_slave.sv
// Bench for spi_codec_reg_slave: SPI master driver, register-file model,
// per-cycle compare process and directed plus randomized frames.
module tb_spi_codec_reg_slave;

  localparam logic [6:0] ID_ADDR = 7'h00;
  localparam logic [7:0] ID_VAL  = 8'h01;
  localparam int         HALF    = 10;

  logic        CLK_50 = 1'b0;
  logic        RESET_n = 1'b0;
  logic [6:0]  iMON_ADDR = '0;
  logic        oWR_STB, oRD_STB, oFRAME_ERR;
  logic [6:0]  oWR_ADDR;
  logic [7:0]  oWR_DATA, oMON_DATA;
  logic [15:0] oFRAME_CNT;

  spi_codec_reg_slave_if spi ();

  spi_codec_reg_slave #(
    .ID_ADDR  (ID_ADDR),
    .ID_VAL   (ID_VAL),
    .MIN_HALF (8)
  ) dut (
    .CLK_50     (CLK_50),
    .RESET_n    (RESET_n),
    .spi        (spi),
    .oWR_STB    (oWR_STB),
    .oWR_ADDR   (oWR_ADDR),
    .oWR_DATA   (oWR_DATA),
    .oRD_STB    (oRD_STB),
    .iMON_ADDR  (iMON_ADDR),
    .oMON_DATA  (oMON_DATA),
    .oFRAME_ERR (oFRAME_ERR),
    .oFRAME_CNT (oFRAME_CNT)
  );

  always #10 CLK_50 = ~CLK_50;

  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_err = 0;

  logic [7:0]  m_reg [128];
  logic [15:0] m_cnt = '0;
  logic [6:0]  m_wa = '0;
  logic [7:0]  m_wd = '0;

  logic quiet = 1'b0;
  logic wr_frame = 1'b0;
  logic deep = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mexp(input logic [6:0] a);
    return (a == ID_ADDR) ? ID_VAL : m_reg[a];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_50);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge CLK_50);
      #2;
      iMON_ADDR = 7'($urandom);
    end
  end

  always @(negedge CLK_50) begin
    if (oWR_STB === 1'b1) n_wr++;
    if (oRD_STB === 1'b1) n_rd++;
    if (oFRAME_ERR === 1'b1) n_err++;
    if (quiet) begin
      chk("mon_data", 32'(oMON_DATA), 32'(mexp(iMON_ADDR)));
      chk("frame_cnt", 32'(oFRAME_CNT), 32'(m_cnt));
      chk("wr_addr", 32'(oWR_ADDR), 32'(m_wa));
      chk("wr_data", 32'(oWR_DATA), 32'(m_wd));
      chk("dout_en_idle", 32'(spi.oDOUT_EN), 32'd0);
    end
    if (wr_frame) chk("dout_write", 32'(spi.oDOUT), 32'd0);
    if (deep) chk("dout_en_act", 32'(spi.oDOUT_EN), 32'd1);
  end

  task automatic bits(input logic [15:0] w, input int nb,
                      output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < nb; i++) begin
      spi.iDIN = (i < 16) ? w[15-i] : 1'($urandom);
      cyc(HALF);
      if (i < 16) rx = {rx[14:0], spi.oDOUT};
      spi.iSCLK = 1'b0;
      cyc(HALF);
      spi.iSCLK = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [6:0] a, input logic rw,
                           input logic [7:0] d, input int nb,
                           output logic [15:0] rx);
    int w0, r0, e0;
    logic [7:0] rdv;
    logic cpl;
    w0 = n_wr;
    r0 = n_rd;
    e0 = n_err;
    rdv = mexp(a);
    cpl = (nb >= 16);
    quiet = 1'b0;
    wr_frame = !rw;
    spi.iCS_n = 1'b0;
    cyc(4);
    deep = 1'b1;
    bits({a, rw, d}, nb, rx);
    cyc(HALF);
    deep = 1'b0;
    spi.iCS_n = 1'b1;
    cyc(2);
    wr_frame = 1'b0;
    cyc(10);
    chk("wr_stb_cnt", 32'(n_wr - w0),
        (cpl && !rw && a != ID_ADDR) ? 32'd1 : 32'd0);
    chk("rd_stb_cnt", 32'(n_rd - r0), (rw && nb >= 8) ? 32'd1 : 32'd0);
    chk("err_cnt", 32'(n_err - e0), cpl ? 32'd0 : 32'd1);
    if (cpl && rw) chk("rd_shift", 32'(rx), {24'd0, rdv});
    if (!rw) chk("wr_shift", 32'(rx), 32'd0);
    if (cpl) begin
      m_cnt = m_cnt + 16'd1;
      if (!rw && a != ID_ADDR) begin
        m_reg[a] = d;
        m_wa = a;
        m_wd = d;
      end
    end
    quiet = 1'b1;
  endtask

  logic [15:0] rx;
  int          w0, r0, e0;

  initial begin
    for (int i = 0; i < 128; i++) m_reg[i] = '0;
    spi.iSCLK = 1'b1;
    spi.iCS_n = 1'b1;
    spi.iDIN  = 1'b0;
    cyc(5);
    chk("rst_wr_stb", 32'(oWR_STB), 32'd0);
    chk("rst_rd_stb", 32'(oRD_STB), 32'd0);
    chk("rst_err", 32'(oFRAME_ERR), 32'd0);
    chk("rst_cnt", 32'(oFRAME_CNT), 32'd0);
    chk("rst_wr_addr", 32'(oWR_ADDR), 32'd0);
    chk("rst_wr_data", 32'(oWR_DATA), 32'd0);
    chk("rst_dout", 32'(spi.oDOUT), 32'd0);
    chk("rst_dout_en", 32'(spi.oDOUT_EN), 32'd0);
    RESET_n = 1'b1;
    cyc(10);
    quiet = 1'b1;

    run_frame(7'h09, 1'b0, 8'h34, 16, rx);
    chk("lit_wr_addr", 32'(oWR_ADDR), 32'h09);
    chk("lit_wr_data", 32'(oWR_DATA), 32'h34);
    chk("lit_cnt1", 32'(oFRAME_CNT), 32'd1);
    run_frame(7'h09, 1'b1, 8'hFF, 16, rx);
    chk("lit_rd09", 32'(rx), 32'h0034);
    run_frame(ID_ADDR, 1'b1, 8'hFF, 16, rx);
    chk("lit_id1", 32'(rx), 32'h0001);
    run_frame(ID_ADDR, 1'b0, 8'h5A, 16, rx);
    run_frame(ID_ADDR, 1'b1, 8'hFF, 16, rx);
    chk("lit_id2", 32'(rx), 32'h0001);
    run_frame(7'h10, 1'b0, 8'hC3, 10, rx);
    chk("lit_abort_cnt", 32'(oFRAME_CNT), 32'd5);
    run_frame(7'h10, 1'b1, 8'hFF, 16, rx);
    chk("lit_abort_reg", 32'(rx), 32'h0000);
    run_frame(7'h10, 1'b0, 8'h3C, 16, rx);
    chk("lit_after_abort", 32'(oWR_DATA), 32'h3C);
    run_frame(7'h22, 1'b0, 8'hA5, 20, rx);
    chk("lit_long_addr", 32'(oWR_ADDR), 32'h22);
    chk("lit_long_data", 32'(oWR_DATA), 32'hA5);
    chk("lit_long_cnt", 32'(oFRAME_CNT), 32'd8);
    run_frame(7'h7F, 1'b0, 8'hE7, 16, rx);
    run_frame(7'h7F, 1'b1, 8'hFF, 16, rx);
    chk("lit_top_addr", 32'(rx), 32'h00E7);

    for (int k = 0; k < 40; k++) begin
      logic [6:0] a;
      logic       rw;
      logic [7:0] d;
      int         kind, nb;
      a    = ($urandom_range(0, 3) == 0) ? 7'($urandom)
                                         : 7'($urandom_range(0, 5));
      rw   = 1'($urandom);
      d    = rw ? 8'hFF : 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind < 7)       nb = 16;
      else if (kind < 9)  nb = $urandom_range(1, 15);
      else                nb = $urandom_range(17, 20);
      run_frame(a, rw, d, nb, rx);
    end

    quiet = 1'b0;
    w0 = n_wr;
    r0 = n_rd;
    e0 = n_err;
    spi.iCS_n = 1'b0;
    cyc(4);
    bits({7'h33, 1'b0, 8'h77}, 6, rx);
    RESET_n = 1'b0;
    cyc(3);
    chk("midrst_cnt", 32'(oFRAME_CNT), 32'd0);
    chk("midrst_wr_addr", 32'(oWR_ADDR), 32'd0);
    chk("midrst_dout_en", 32'(spi.oDOUT_EN), 32'd0);
    RESET_n = 1'b1;
    cyc(4);
    bits({7'h44, 1'b0, 8'h66}, 16, rx);
    cyc(HALF);
    chk("midrst_wr", 32'(n_wr - w0), 32'd0);
    chk("midrst_rd", 32'(n_rd - r0), 32'd0);
    chk("midrst_err", 32'(n_err - e0), 32'd0);
    chk("midrst_cnt2", 32'(oFRAME_CNT), 32'd0);
    spi.iCS_n = 1'b1;
    cyc(12);
    for (int i = 0; i < 128; i++) m_reg[i] = '0;
    m_cnt = '0;
    m_wa  = '0;
    m_wd  = '0;
    quiet = 1'b1;
    run_frame(7'h44, 1'b0, 8'h99, 16, rx);
    chk("post_rst_cnt", 32'(oFRAME_CNT), 32'd1);
    run_frame(7'h44, 1'b1, 8'hFF, 16, rx);
    chk("post_rst_rd", 32'(rx), 32'h0099);
    run_frame(7'h09, 1'b1, 8'hFF, 16, rx);
    chk("post_rst_clr", 32'(rx), 32'h0000);
    cyc(20);
    quiet = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_codec_reg_slave.md
# spi_codec_reg_slave

SPI responder that emulates the audio codec's 128 × 8 control-register file. It is the far end of the codec-configuration SPI master: it accepts the 16-bit write and read-back frames that the master issues. It stores written data and returns register contents on DOUT during read frames. It is used in simulation and on-board loopback to bring up the configuration path without the codec, and it exposes a write-event port and a monitor read port to local logic.

## Interface
Parameters:
- ID_ADDR, 7'h00, address of the read-only ID register.
- ID_VAL, 8'h01, value returned from ID_ADDR; writes to ID_ADDR are dropped.
- MIN_HALF, 8, minimum SCLK half-period in CLK_50 cycles; documentation/assertion only.

Ports:
- CLK_50  in  1  system clock, 50 MHz
- RESET_n  in  1  reset, asynchronous, active-low
- iSCLK  in  1  SPI clock from the master, idle high, asynchronous to CLK_50
- iCS_n  in  1  SPI chip select, active low
- iDIN  in  1  master-to-slave serial data, MSB first
- oDOUT  out  1  slave-to-master serial data
- oDOUT_EN  out  1  output enable for the DOUT pad; 1 while CS is active
- oWR_STB  out  1  one-cycle pulse on each committed register write
- oWR_ADDR  out  7  address of the last committed write
- oWR_DATA  out  8  data of the last committed write
- oRD_STB  out  1  one-cycle pulse when a read frame's address is decoded
- iMON_ADDR  in  7  local monitor read address
- oMON_DATA  out  8  register contents at iMON_ADDR, combinational
- oFRAME_ERR  out  1  one-cycle pulse when CS deasserts mid-frame
- oFRAME_CNT  out  16  count of completed 16-bit frames, wraps

## Operation
- Frame format, 16 bits, MSB first:
  - bits [15:9] address A
  - bit [8] R/W, where 1 is read
  - bits [7:0] data D. For a write, D is the write data. For a read, the master sends 8'hFF, which is ignored.
- Bit timing:
  - The master changes DIN after SCLK rises and samples DOUT at SCLK fall.
  - The slave samples DIN on SCLK falling edges.
  - The slave updates DOUT on SCLK rising edges.
- iSCLK, iCS_n and iDIN each pass through a 2-flop synchronizer. Edges are detected on the synchronized signals by comparison with a third registered copy.
- States:
  - WAIT_IDLE. Entered at reset. Moves to IDLE when synchronized CS_n = 1.
  - IDLE. CS falling moves to SHIFT, clearing the bit counter BC and the shift register.
  - SHIFT. Each SCLK fall shifts DIN into SR and increments BC.
  - DONE. Entered at BC = 16. Further SCLK edges are ignored and oDOUT = 0. CS rising moves to IDLE.
- CS rising while in SHIFT with BC < 16:
  - move to IDLE
  - pulse oFRAME_ERR
  - no write and no oFRAME_CNT increment
- Read path:
  - At BC = 8 (R/W bit captured) with R/W = 1, load the output register OR with reg[A] (ID_VAL if A = ID_ADDR) and pulse oRD_STB.
  - On each following SCLK rise, drive oDOUT = OR[7] and shift OR left. The master therefore captures reg[A][7:0] on its last 8 falls.
  - During BC 0–8, and for entire write frames, oDOUT = 0.
- Write commit, at BC = 16:
  - If R/W = 0 and A ≠ ID_ADDR: write reg[A] ← D, set oWR_ADDR/oWR_DATA, and pulse oWR_STB.
  - For any completed frame (read or write): increment oFRAME_CNT.
- oDOUT_EN = ~CS_n after synchronization.
- Reset values:
  - all registers 8'h00
  - state WAIT_IDLE
  - oDOUT 0, oDOUT_EN 0
  - oWR_STB, oRD_STB and oFRAME_ERR 0
  - oWR_ADDR and oWR_DATA 0
  - oFRAME_CNT 0
- Reset mid-frame aborts the frame with no write. The slave does not re-engage until CS_n is seen high (WAIT_IDLE).

## Timing
- Pin-to-action latency is 3 CLK_50 cycles (2 synchronizer stages plus edge detect). A DOUT update lands at most 4 cycles after the SCLK rise at the pin. This requires an SCLK half-period ≥ MIN_HALF cycles; the master's 400 kHz mode gives 62.
- oWR_STB is asserted the cycle after the 16th fall is detected. oMON_DATA reflects the new value in the cycle after oWR_STB.
- oRD_STB is asserted the cycle after the 8th fall is detected. OR is loaded in the same cycle.
- A simultaneous SCLK edge and CS rising in the same cycle: CS takes priority and the edge is ignored.
- A monitor read of the address being written in the same cycle returns the old value.

## Structure
- Shared package constants:
  - FRAME_BITS = 16
  - ADDR_W = 7
  - DATA_W = 8
  - RW_BIT = 8
  - state encoding: WAIT_IDLE, IDLE, SHIFT, DONE
- Sub-module spi_codec_regs: 128 × 8 flop array with one synchronous write port and two asynchronous read ports (SPI read, monitor), reset to 0. The ID override is applied in the parent.
- Top level contains the synchronizers, edge detect, FSM, SR/OR/BC and the counters.

## Test plan
- Write 16'h1234 (A = 0x09, W, D = 0x34) → one oWR_STB with oWR_ADDR = 0x09 and oWR_DATA = 0x34, oMON_DATA@0x09 = 0x34, oFRAME_CNT = 1.
- Then read {7'h09, 1'b1, 8'hFF} → master shifts in 16'h0034, oRD_STB pulses once, no oWR_STB.
- Read ID_ADDR → 8'h01. Write 0x5A to ID_ADDR, then read again → still 8'h01, no oWR_STB.
- Raise CS after 10 bits of a write to 0x10 → oFRAME_ERR pulse, reg[0x10] unchanged, oFRAME_CNT unchanged. The next full frame is decoded correctly.
- Send 20 SCLK pulses within one CS window on a write frame → exactly one write, taken from the first 16 bits, and oDOUT stays 0.
- Assert RESET_n low mid-frame while CS is held low, then release → no activity until CS goes high. The next frame works and all other registers read 0.
